// File: rtl/riscv_pkg.sv
// Shared core types: datapath width, register count, forwarding select codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;

    // EX operand-mux selects
    localparam logic [1:0] FWD_NONE = 2'b00;  // regfile / ID-EX value
    localparam logic [1:0] FWD_MEM  = 2'b10;  // EX/MEM result
    localparam logic [1:0] FWD_WB   = 2'b01;  // MEM/WB writeback value

    typedef logic [4:0] reg_idx_t;

endpackage : riscv_pkg

// File: rtl/fwd_unit.sv
// EX-stage forwarding select generation for both ALU operands.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; selects follow the pipeline register contents.
//
// Ports: mem_RegWrite/mem_rd (EX/MEM producer), wb_RegWrite/wb_rd (MEM/WB producer),
//        ex_rs1/ex_rs2 (ID/EX consumers) -> ForwardA/ForwardB.
module fwd_unit
    import riscv_pkg::*;
(
    input  logic       mem_RegWrite,
    input  reg_idx_t   mem_rd,
    input  logic       wb_RegWrite,
    input  reg_idx_t   wb_rd,
    input  reg_idx_t   ex_rs1,
    input  reg_idx_t   ex_rs2,
    output logic [1:0] ForwardA,
    output logic [1:0] ForwardB
);

    // The EX/MEM stage holds the younger producer, so it is tested first.
    function automatic logic [1:0] fwd_sel(input reg_idx_t rs);
        logic [1:0] sel;
        sel = FWD_NONE;
        if (mem_RegWrite && (mem_rd != '0) && (mem_rd == rs)) begin
            sel = FWD_MEM;
        end else if (wb_RegWrite && (wb_rd != '0) && (wb_rd == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        ForwardA = fwd_sel(ex_rs1);
        ForwardB = fwd_sel(ex_rs2);
    end

endmodule : fwd_unit

// File: rtl/wb_regfile_fwd.sv
// Writeback stage: selects the WB value, commits it to the 32x64 regfile, serves two ID read ports, counts commits.
// Latency: commit visible on reads 1 cycle after the write (same cycle with WB_REGFILE_BYPASS_EN defined).
// Backpressure: none; every qualifying writeback commits unconditionally.
//
// Ports: clk/reset (sync, active-high); wb_* MEM/WB contents; id_rs1/2 read addresses;
//        ex_rs1/2, mem_RegWrite/mem_rd for forwarding; outputs rd_data1/2, wb_data,
//        ForwardA/B, wb_count.
// Build option: define WB_REGFILE_BYPASS_EN for write-through reads of the register being committed.
module wb_regfile_fwd
    import riscv_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_RegWrite,
    input  logic             wb_MemtoReg,
    input  logic [XLEN-1:0]  wb_ReadData,
    input  logic [XLEN-1:0]  wb_ALU_result,
    input  reg_idx_t         wb_rd,
    input  reg_idx_t         id_rs1,
    input  reg_idx_t         id_rs2,
    input  reg_idx_t         ex_rs1,
    input  reg_idx_t         ex_rs2,
    input  logic             mem_RegWrite,
    input  reg_idx_t         mem_rd,
    output logic [XLEN-1:0]  rd_data1,
    output logic [XLEN-1:0]  rd_data2,
    output logic [XLEN-1:0]  wb_data,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [CNT_W-1:0] wb_count
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [CNT_W-1:0] r_wb_count;
    logic             w_commit;
    logic [XLEN-1:0]  w_rd1_raw;
    logic [XLEN-1:0]  w_rd2_raw;

    assign wb_data  = wb_MemtoReg ? wb_ReadData : wb_ALU_result;
    // x0 writes are discarded here so neither the array nor the counter sees them.
    assign w_commit = wb_RegWrite && (wb_rd != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wb_count <= '0;
        end else if (w_commit) begin
            r_regs[wb_rd] <= wb_data;
            r_wb_count    <= r_wb_count + CNT_W'(1);
        end
    end

`ifdef WB_REGFILE_BYPASS_EN
    assign w_rd1_raw = (w_commit && (wb_rd == id_rs1)) ? wb_data : r_regs[id_rs1];
    assign w_rd2_raw = (w_commit && (wb_rd == id_rs2)) ? wb_data : r_regs[id_rs2];
`else
    assign w_rd1_raw = r_regs[id_rs1];
    assign w_rd2_raw = r_regs[id_rs2];
`endif

    // x0 reads as zero independent of whatever the array slot holds.
    assign rd_data1 = (id_rs1 == '0) ? '0 : w_rd1_raw;
    assign rd_data2 = (id_rs2 == '0) ? '0 : w_rd2_raw;
    assign wb_count = r_wb_count;

    fwd_unit u_fwd_unit (
        .mem_RegWrite (mem_RegWrite),
        .mem_rd       (mem_rd),
        .wb_RegWrite  (wb_RegWrite),
        .wb_rd        (wb_rd),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ForwardA     (ForwardA),
        .ForwardB     (ForwardB)
    );

endmodule : wb_regfile_fwd

// File: tb/tb_wb_regfile_fwd.sv
// Scoreboard bench for wb_regfile_fwd: expectations are queued with the stimulus
// and drained against the DUT outputs mid-cycle.
// Latency: n/a.  Backpressure: n/a.
module tb_wb_regfile_fwd;
    import riscv_pkg::*;

    localparam int CNT_W = 64;

    // observed-output selectors for scoreboard entries
    localparam int O_RD1 = 0;
    localparam int O_RD2 = 1;
    localparam int O_WBD = 2;
    localparam int O_FA  = 3;
    localparam int O_FB  = 4;
    localparam int O_CNT = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             wb_RegWrite;
    logic             wb_MemtoReg;
    logic [XLEN-1:0]  wb_ReadData;
    logic [XLEN-1:0]  wb_ALU_result;
    reg_idx_t         wb_rd;
    reg_idx_t         id_rs1;
    reg_idx_t         id_rs2;
    reg_idx_t         ex_rs1;
    reg_idx_t         ex_rs2;
    logic             mem_RegWrite;
    reg_idx_t         mem_rd;
    logic [XLEN-1:0]  rd_data1;
    logic [XLEN-1:0]  rd_data2;
    logic [XLEN-1:0]  wb_data;
    logic [1:0]       ForwardA;
    logic [1:0]       ForwardB;
    logic [CNT_W-1:0] wb_count;

    int n_chk = 0;
    int n_err = 0;

    string           q_tag [$];
    int              q_sel [$];
    logic [63:0]     q_exp [$];

    always #5 clk = ~clk;

    wb_regfile_fwd #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .wb_RegWrite   (wb_RegWrite),
        .wb_MemtoReg   (wb_MemtoReg),
        .wb_ReadData   (wb_ReadData),
        .wb_ALU_result (wb_ALU_result),
        .wb_rd         (wb_rd),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .mem_RegWrite  (mem_RegWrite),
        .mem_rd        (mem_rd),
        .rd_data1      (rd_data1),
        .rd_data2      (rd_data2),
        .wb_data       (wb_data),
        .ForwardA      (ForwardA),
        .ForwardB      (ForwardB),
        .wb_count      (wb_count)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int sel, input logic [63:0] exp);
        q_tag.push_back(tag);
        q_sel.push_back(sel);
        q_exp.push_back(exp);
    endtask

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            O_RD1:   return rd_data1;
            O_RD2:   return rd_data2;
            O_WBD:   return wb_data;
            O_FA:    return 64'(ForwardA);
            O_FB:    return 64'(ForwardB);
            default: return wb_count;
        endcase
    endfunction

    // let combinational outputs settle, then compare every pending expectation
    task automatic drain();
        #2;
        while (q_exp.size() > 0) begin
            chk(q_tag.pop_front(), observe(q_sel.pop_front()), q_exp.pop_front());
        end
    endtask

    // inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input reg_idx_t rd, input logic [63:0] val);
        wb_RegWrite   = 1'b1;
        wb_MemtoReg   = 1'b0;
        wb_ALU_result = val;
        wb_rd         = rd;
        tick();
        wb_RegWrite   = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        wb_RegWrite   = 1'b0;
        wb_MemtoReg   = 1'b0;
        wb_ReadData   = '0;
        wb_ALU_result = '0;
        wb_rd         = '0;
        id_rs1        = '0;
        id_rs2        = '0;
        ex_rs1        = '0;
        ex_rs2        = '0;
        mem_RegWrite  = 1'b0;
        mem_rd        = '0;

        // 1. reset for two cycles, all registers read back zero
        tick();
        tick();
        reset = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            id_rs1 = reg_idx_t'(i);
            id_rs2 = reg_idx_t'(i);
            expect_out("reset_rd1", O_RD1, 64'h0);
            expect_out("reset_rd2", O_RD2, 64'h0);
            drain();
        end
        expect_out("reset_cnt", O_CNT, 64'h0);
        drain();

        // 2. ALU-result writeback to x5
        wb_RegWrite   = 1'b1;
        wb_MemtoReg   = 1'b0;
        wb_ALU_result = 64'hDEAD_BEEF;
        wb_ReadData   = 64'h9999;
        wb_rd         = 5'd5;
        expect_out("wbdata_alu", O_WBD, 64'hDEAD_BEEF);
        drain();
        tick();
        wb_RegWrite = 1'b0;
        id_rs1      = 5'd5;
        expect_out("x5_alu", O_RD1, 64'hDEAD_BEEF);
        expect_out("cnt_1", O_CNT, 64'd1);
        drain();

        // 3. load data aimed at x0 is discarded, then committed to x7
        wb_RegWrite = 1'b1;
        wb_MemtoReg = 1'b1;
        wb_ReadData = 64'h1234;
        wb_rd       = 5'd0;
        id_rs1      = 5'd0;
        expect_out("wbdata_load", O_WBD, 64'h1234);
        expect_out("x0_read_wr", O_RD1, 64'h0);
        drain();
        tick();
        wb_RegWrite = 1'b0;
        id_rs2      = 5'd5;
        expect_out("x0_after", O_RD1, 64'h0);
        expect_out("x5_kept", O_RD2, 64'hDEAD_BEEF);
        expect_out("cnt_x0", O_CNT, 64'd1);
        drain();
        wb_RegWrite = 1'b1;
        wb_rd       = 5'd7;
        tick();
        wb_RegWrite = 1'b0;
        wb_MemtoReg = 1'b0;
        id_rs1      = 5'd7;
        expect_out("x7_load", O_RD1, 64'h1234);
        expect_out("cnt_2", O_CNT, 64'd2);
        drain();

        // 4. forwarding priority (combinational only, no clock edge taken)
        mem_RegWrite = 1'b1;
        mem_rd       = 5'd3;
        wb_RegWrite  = 1'b1;
        wb_rd        = 5'd3;
        ex_rs1       = 5'd3;
        ex_rs2       = 5'd3;
        expect_out("fa_mem_wins", O_FA, 64'(FWD_MEM));
        expect_out("fb_mem_wins", O_FB, 64'(FWD_MEM));
        drain();
        mem_RegWrite = 1'b0;
        expect_out("fa_wb", O_FA, 64'(FWD_WB));
        drain();
        mem_RegWrite = 1'b1;
        mem_rd       = 5'd0;
        wb_rd        = 5'd0;
        ex_rs2       = 5'd0;
        expect_out("fb_x0", O_FB, 64'(FWD_NONE));
        drain();
        mem_rd = 5'd3;
        ex_rs1 = 5'd4;
        expect_out("fa_nomatch", O_FA, 64'(FWD_NONE));
        drain();
        mem_RegWrite = 1'b0;
        wb_RegWrite  = 1'b0;
        wb_rd        = 5'd4;
        expect_out("fa_wb_off", O_FA, 64'(FWD_NONE));
        drain();

        // 5. same-cycle write and read of x9
        wb_write(5'd9, 64'h11);
        wb_RegWrite   = 1'b1;
        wb_ALU_result = 64'hAA;
        wb_rd         = 5'd9;
        id_rs2        = 5'd9;
`ifdef WB_REGFILE_BYPASS_EN
        expect_out("x9_same_cycle", O_RD2, 64'hAA);
`else
        expect_out("x9_same_cycle", O_RD2, 64'h11);
`endif
        drain();
        tick();
        wb_RegWrite = 1'b0;
        expect_out("x9_next_cycle", O_RD2, 64'hAA);
        expect_out("cnt_4", O_CNT, 64'd4);
        drain();

        // 6. reset wins over a concurrent write
        wb_write(5'd4, 64'h33);
        reset         = 1'b1;
        wb_RegWrite   = 1'b1;
        wb_ALU_result = 64'h55;
        wb_rd         = 5'd4;
        expect_out("wbdata_in_reset", O_WBD, 64'h55);
        drain();
        tick();
        reset       = 1'b0;
        wb_RegWrite = 1'b0;
        id_rs1      = 5'd4;
        id_rs2      = 5'd9;
        expect_out("x4_reset", O_RD1, 64'h0);
        expect_out("x9_reset", O_RD2, 64'h0);
        expect_out("cnt_reset", O_CNT, 64'h0);
        drain();

        // counter wrap from all-ones
        force dut.r_wb_count = {CNT_W{1'b1}};
        tick();
        release dut.r_wb_count;
        expect_out("cnt_preload", O_CNT, 64'hFFFF_FFFF_FFFF_FFFF);
        drain();
        wb_write(5'd1, 64'h7);
        id_rs1 = 5'd1;
        expect_out("cnt_wrap", O_CNT, 64'h0);
        expect_out("x1_after_wrap", O_RD1, 64'h7);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_wb_regfile_fwd
